multibank_buffer_slv: RTL and testbench

- Parametrised successor of the single-bank blocking write buffer. It sits between the DMA's AXI write-data channel and the systolic-array row feeder.
- It holds NUM_BANKS independent banks. Each bank is filled as one INCR burst of DEPTH beats, then drained one row per handshake.
- Draining uses a valid/ready stream. While one bank drains, another bank can fill, so filling and pushing overlap back-to-back.

---
 rtl/multibank_buffer_slv_if.sv | 33 +++
 rtl/multibank_buffer_slv.sv | 159 +++++++++++++++
 tb/tb_multibank_buffer_slv.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/multibank_buffer_slv_if.sv
// Bus bundle for multibank_buffer_slv: AXI write-data beats in, row stream out.
// The slave modport is the buffer; the master modport is the DMA/consumer side.
interface multibank_buffer_slv_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_BANKS = 2
);
  localparam int BANK_W = $clog2(NUM_BANKS);

  logic                  grant;
  logic [1:0]            aw_burst;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [DATA_W-1:0]     s_axi_wdata;
  logic [DATA_W/8-1:0]   s_axi_wstrb;
  logic                  s_axi_wlast;
  logic                  available;
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_W-1:0]     data;
  logic [BANK_W-1:0]     push_bank;
  logic                  push_last;
  logic                  err;

  modport slave (
    input  grant, aw_burst, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, push_ready,
    output s_axi_wready, available, push_valid, data, push_bank, push_last, err
  );

  modport master (
    output grant, aw_burst, s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast, push_ready,
    input  s_axi_wready, available, push_valid, data, push_bank, push_last, err
  );
endinterface

// File: rtl/multibank_buffer_slv.sv
// Multi-bank write buffer: each bank fills with one INCR burst, then drains as a row stream.
// Optional per-byte write enables via macro MULTIBANK_BUF_STRB_EN.
module multibank_buffer_slv #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter int NUM_BANKS = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  multibank_buffer_slv_if.slave  bus
);
  localparam int ROW_W     = $clog2(DEPTH);
  localparam int BANK_W    = $clog2(NUM_BANKS);
  localparam int ADDR_W    = ROW_W + BANK_W;
  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_LOADING,
    BANK_FULL,
    BANK_PUSHING
  } bank_state_t;

  bank_state_t         bank_state [NUM_BANKS];

  logic [BANK_W-1:0]   wr_ptr_reg;
  logic [ROW_W-1:0]    wr_row_reg;
  logic                err_reg;

  logic [BANK_W-1:0]   fetch_ptr_reg;
  logic [ROW_W-1:0]    fetch_row_reg;
  logic                push_valid_reg;
  logic                push_last_reg;
  logic [BANK_W-1:0]   push_bank_reg;
  logic [DATA_W-1:0]   data_reg;

  logic [DATA_W-1:0]   mem [MEM_DEPTH];

  bank_state_t         wr_state;
  bank_state_t         fetch_state;
  logic                grant_take;
  logic                wready;
  logic                beat_acc;
  logic                beat_last;
  logic                rd_en;
  logic                handshake;
  logic                drain_done;

  function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  always_comb begin
    wr_state    = bank_state[wr_ptr_reg];
    fetch_state = bank_state[fetch_ptr_reg];
    grant_take  = bus.grant && (wr_state == BANK_IDLE);
    wready      = (wr_state == BANK_LOADING) && (bus.aw_burst == 2'b01);
    beat_acc    = bus.s_axi_wvalid && wready;
    beat_last   = beat_acc && (wr_row_reg == LAST_ROW);
    handshake   = push_valid_reg && bus.push_ready;
    drain_done  = handshake && push_last_reg;
    // Prefetch: read the next row whenever the output register is empty or being consumed.
    rd_en       = ((fetch_state == BANK_FULL) || (fetch_state == BANK_PUSHING)) &&
                  (!push_valid_reg || bus.push_ready);
  end

  generate
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      bank_state_t st_reg;
      bank_state_t st_next;

      always_comb begin
        st_next = st_reg;
        case (st_reg)
          BANK_IDLE:
            if (grant_take && (wr_ptr_reg == BANK_W'(gi))) st_next = BANK_LOADING;
          BANK_LOADING:
            if (beat_last && (wr_ptr_reg == BANK_W'(gi))) st_next = BANK_FULL;
          BANK_FULL:
            if (rd_en && (fetch_ptr_reg == BANK_W'(gi))) st_next = BANK_PUSHING;
          BANK_PUSHING:
            if (drain_done && (push_bank_reg == BANK_W'(gi))) st_next = BANK_IDLE;
          default:
            st_next = BANK_IDLE;
        endcase
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) st_reg <= BANK_IDLE;
        else       st_reg <= st_next;
      end

      assign bank_state[gi] = st_reg;
    end
  endgenerate

  // Write side: the FSM advances on beat count alone; wlast only feeds the error flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      wr_row_reg <= '0;
      err_reg    <= 1'b0;
    end else if (beat_acc) begin
      wr_row_reg <= wr_row_reg + 1'b1;
      if (beat_last) wr_ptr_reg <= next_bank(wr_ptr_reg);
      if (bus.s_axi_wlast != (wr_row_reg == LAST_ROW)) err_reg <= 1'b1;
    end
  end

`ifdef MULTIBANK_BUF_STRB_EN
  always_ff @(posedge clk_i) begin
    if (beat_acc) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (bus.s_axi_wstrb[b]) mem[{wr_ptr_reg, wr_row_reg}][b*8 +: 8] <= bus.s_axi_wdata[b*8 +: 8];
      end
    end
  end
`else
  logic unused_strb;
  assign unused_strb = ^bus.s_axi_wstrb;

  always_ff @(posedge clk_i) begin
    if (beat_acc) mem[{wr_ptr_reg, wr_row_reg}] <= bus.s_axi_wdata;
  end
`endif

  // Read side: the registered memory output doubles as the push data register,
  // so holding rd_en low keeps data stable during back-pressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_ptr_reg  <= '0;
      fetch_row_reg  <= '0;
      push_valid_reg <= 1'b0;
      push_last_reg  <= 1'b0;
      push_bank_reg  <= '0;
      data_reg       <= '0;
    end else if (rd_en) begin
      data_reg       <= mem[{fetch_ptr_reg, fetch_row_reg}];
      push_valid_reg <= 1'b1;
      push_bank_reg  <= fetch_ptr_reg;
      push_last_reg  <= (fetch_row_reg == LAST_ROW);
      fetch_row_reg  <= fetch_row_reg + 1'b1;
      if (fetch_row_reg == LAST_ROW) fetch_ptr_reg <= next_bank(fetch_ptr_reg);
    end else if (handshake) begin
      push_valid_reg <= 1'b0;
      push_last_reg  <= 1'b0;
    end
  end

  assign bus.s_axi_wready = wready;
  assign bus.available    = (wr_state == BANK_IDLE);
  assign bus.push_valid   = push_valid_reg;
  assign bus.data         = data_reg;
  assign bus.push_bank    = push_bank_reg;
  assign bus.push_last    = push_last_reg;
  assign bus.err          = err_reg;
endmodule

// File: tb/tb_multibank_buffer_slv.sv
// Directed scoreboard bench for multibank_buffer_slv (2 banks x 16 rows x 64 bits).
module tb_multibank_buffer_slv;
  localparam int DATA_W    = 64;
  localparam int DEPTH     = 16;
  localparam int NUM_BANKS = 2;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  multibank_buffer_slv_if #(.DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS)) bus ();

  multibank_buffer_slv #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_BANKS(NUM_BANKS)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        b;
    logic        l;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  logic wbank    = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks hold-during-stall.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic        prev_bank;
  logic        prev_last;
  always @(negedge clk_i) begin
    if (rst_i) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", bus.push_valid, 1);
        chk("hold_data", bus.data, prev_data);
        chk("hold_bank", bus.push_bank, prev_bank);
        chk("hold_last", bus.push_last, prev_last);
      end
      if (bus.push_valid && bus.push_ready) begin
        chk("row_expected", q.size() != 0, 1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          $display("row bank=%0d data=%0h last=%0b", bus.push_bank, bus.data, bus.push_last);
          chk("row_data", bus.data, e.d);
          chk("row_bank", bus.push_bank, e.b);
          chk("row_last", bus.push_last, e.l);
        end
      end
      prev_stall <= bus.push_valid && !bus.push_ready;
      prev_data  <= bus.data;
      prev_bank  <= bus.push_bank;
      prev_last  <= bus.push_last;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_wready"}, bus.s_axi_wready, 0);
    chk({tag, "_valid"}, bus.push_valid, 0);
    chk({tag, "_last"}, bus.push_last, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_bank"}, bus.push_bank, 0);
    chk({tag, "_data"}, bus.data, 0);
    chk({tag, "_avail"}, bus.available, 1);
  endtask

  task automatic do_reset();
    rst_i            = 1'b1;
    bus.grant        = 1'b0;
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    q.delete();
    wbank = 1'b0;
  endtask

  task automatic grant_bank();
    bus.grant = 1'b1;
    step();
    bus.grant = 1'b0;
  endtask

  task automatic send_beats(input logic [63:0] base, input int first, input int n,
                            input int last_at, input logic queue_it);
    for (int i = first; i < first + n; i++) begin
      int t;
      bus.s_axi_wdata  = base + 64'(i);
      bus.s_axi_wlast  = (i == last_at);
      bus.s_axi_wvalid = 1'b1;
      t = 0;
      @(negedge clk_i);
      while (!bus.s_axi_wready && t < 50) begin
        @(negedge clk_i);
        t++;
      end
      chk("wready_wait", bus.s_axi_wready, 1);
      step();
      if (queue_it) q.push_back('{d: base + 64'(i), b: wbank, l: (i == DEPTH - 1)});
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
  endtask

  task automatic burst(input logic [63:0] base);
    grant_bank();
    send_beats(base, 0, DEPTH, DEPTH - 1, 1'b1);
    wbank = ~wbank;
  endtask

  task automatic wait_drain(input string tag);
    for (int t = 0; t < 300 && q.size() != 0; t++) step();
    chk(tag, q.size(), 0);
  endtask

  initial begin
    rst_i            = 1'b1;
    bus.grant        = 1'b0;
    bus.aw_burst     = 2'b01;
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wdata  = '0;
    bus.s_axi_wstrb  = '1;
    bus.s_axi_wlast  = 1'b0;
    bus.push_ready   = 1'b0;
    do_reset();
    check_reset("rst0");

    // Single burst, consumer always ready.
    bus.push_ready = 1'b1;
    burst(64'h100);
    wait_drain("t1_drain");
    chk("t1_err", bus.err, 0);
    chk("t1_valid_idle", bus.push_valid, 0);

    // Fill both banks under back-pressure, then drain back-to-back.
    do_reset();
    bus.push_ready = 1'b0;
    burst(64'h200);
    burst(64'h300);
    @(negedge clk_i);
    chk("full_avail", bus.available, 0);
    chk("full_valid", bus.push_valid, 1);
    chk("full_data", bus.data, 64'h200);
    chk("full_bank", bus.push_bank, 0);
    step();
    bus.grant        = 1'b1;
    bus.s_axi_wvalid = 1'b1;
    bus.s_axi_wdata  = 64'hdead;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("full_wready", bus.s_axi_wready, 0);
      chk("full_avail_g", bus.available, 0);
      step();
    end
    bus.grant        = 1'b0;
    bus.s_axi_wvalid = 1'b0;
    bus.push_ready   = 1'b1;
    for (int i = 0; i < 2 * DEPTH; i++) begin
      @(negedge clk_i);
      chk("b2b_valid", bus.push_valid, 1);
      step();
    end
    @(negedge clk_i);
    chk("b2b_done_valid", bus.push_valid, 0);
    chk("b2b_done_q", q.size(), 0);
    chk("b2b_avail", bus.available, 1);
    chk("b2b_no_grant", bus.s_axi_wready, 0);
    step();

    // Consumer ready toggling every cycle.
    bus.push_ready = 1'b0;
    burst(64'h400);
    for (int t = 0; t < 100 && q.size() != 0; t++) begin
      bus.push_ready = ~bus.push_ready;
      step();
    end
    chk("toggle_done", q.size(), 0);
    bus.push_ready = 1'b1;
    step();

    // Early wlast on beat 7: error sticks, bank still takes 16 beats.
    grant_bank();
    send_beats(64'h500, 0, 7, 7, 1'b1);
    chk("wlast_err_before", bus.err, 0);
    send_beats(64'h500, 7, 1, 7, 1'b1);
    chk("wlast_err_set", bus.err, 1);
    send_beats(64'h500, 8, 8, 7, 1'b1);
    wbank = ~wbank;
    wait_drain("wlast_drain");
    chk("wlast_err_sticky", bus.err, 1);
    chk("wlast_valid_idle", bus.push_valid, 0);

    // Reset in the middle of a burst discards it.
    grant_bank();
    send_beats(64'h700, 0, 5, -1, 1'b0);
    do_reset();
    check_reset("rst_mid");
    bus.push_ready = 1'b1;
    burst(64'h600);
    wait_drain("post_rst_drain");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("post_rst_quiet", bus.push_valid, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
